// File: rtl/bin2bcd_pkg.sv
// Shared widths and FSM state encoding for the BCD converter arbiter.
package bin2bcd_pkg;
  localparam int C_BIN_W  = 27;
  localparam int C_BCD_W  = 32;
  localparam int C_DIGITS = 8;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2
  } state_t;
endpackage

// File: rtl/bcd_conv_arbiter_if.sv
// Requester and converter-core signal bundle; directions are named from the arbiter's side.
interface bcd_conv_arbiter_if #(parameter int C_CH = 4);
  import bin2bcd_pkg::*;

  logic [C_CH-1:0]         REQ_i;
  logic [C_BIN_W*C_CH-1:0] DAT_i;
  logic [C_CH-1:0]         ACK_o;
  logic [C_CH-1:0]         DONE_o;
  logic [C_CH-1:0]         ERR_o;
  logic [C_BCD_W-1:0]      QQ_o;
  logic                    CORE_REQ_o;
  logic [C_BIN_W-1:0]      CORE_DAT_o;
  logic [C_BCD_W-1:0]      CORE_QQ_i;
  logic                    CORE_DONE_i;

  modport slave (
    input  REQ_i, DAT_i, CORE_QQ_i, CORE_DONE_i,
    output ACK_o, DONE_o, ERR_o, QQ_o, CORE_REQ_o, CORE_DAT_o
  );

  modport master (
    output REQ_i, DAT_i, CORE_QQ_i, CORE_DONE_i,
    input  ACK_o, DONE_o, ERR_o, QQ_o, CORE_REQ_o, CORE_DAT_o
  );
endinterface

// File: rtl/bcd_rr_pick.sv
// Combinational round-robin picker: first requester found searching upward from i_last+1.
module bcd_rr_pick #(
  parameter int C_CH    = 4,
  parameter int C_IDX_W = $clog2(C_CH)
) (
  input  logic [C_CH-1:0]    i_req,
  input  logic [C_IDX_W-1:0] i_last,
  output logic [C_IDX_W-1:0] o_idx,
  output logic               o_vld
);
  always_comb begin
    o_idx = '0;
    o_vld = 1'b0;
    // farthest offset first, so the nearest requester after i_last is assigned last and wins
    for (int i = C_CH; i >= 1; i--) begin
      if (i_req[C_IDX_W'((int'(i_last) + i) % C_CH)]) begin
        o_idx = C_IDX_W'((int'(i_last) + i) % C_CH);
        o_vld = 1'b1;
      end
    end
  end
endmodule

// File: rtl/bcd_conv_arbiter.sv
// Shares one binary-to-BCD converter core among C_CH requesters with round-robin grant and timeout.
//   state    | meaning
//   ST_IDLE  | waiting for any request, picks winner and latches its operand
//   ST_ISSUE | one cycle: CORE_REQ_o and ACK_o high, timeout counter cleared
//   ST_WAIT  | waiting for core done strobe or timeout
module bcd_conv_arbiter
  import bin2bcd_pkg::*;
#(
  parameter int C_CH  = 4,
  parameter int C_TMO = 63
) (
  input  logic                CK_i,
  input  logic                XARST_i,
  input  logic                EN_CK_i,
  bcd_conv_arbiter_if.slave   bus
);
  localparam int C_IDX_W = $clog2(C_CH);
  localparam int C_TMO_W = $clog2(C_TMO + 1);

  state_t               r_state;
  logic [C_IDX_W-1:0]   r_g;
  logic [C_IDX_W-1:0]   r_last;
  logic [C_TMO_W-1:0]   r_tmo;
  logic [C_CH-1:0]      r_ack;
  logic [C_CH-1:0]      r_done;
  logic [C_CH-1:0]      r_err;
  logic [C_BCD_W-1:0]   r_qq;
  logic                 r_core_req;
  logic [C_BIN_W-1:0]   r_core_dat;

  logic [C_IDX_W-1:0]   w_win;
  logic                 w_vld;
  logic [C_BIN_W-1:0]   w_dat;
  logic [C_CH-1:0]      w_win_mask;
  logic [C_CH-1:0]      w_g_mask;

  bcd_rr_pick #(.C_CH(C_CH), .C_IDX_W(C_IDX_W)) u_pick (
    .i_req  (bus.REQ_i),
    .i_last (r_last),
    .o_idx  (w_win),
    .o_vld  (w_vld)
  );

  always_comb begin
    w_dat = '0;
    for (int c = 0; c < C_CH; c++) begin
      if (w_win == C_IDX_W'(c)) w_dat = bus.DAT_i[c*C_BIN_W +: C_BIN_W];
    end
  end

  assign w_win_mask = C_CH'(1) << w_win;
  assign w_g_mask   = C_CH'(1) << r_g;

  always_ff @(posedge CK_i) begin
    if (!XARST_i) begin
      r_state    <= ST_IDLE;
      r_g        <= '0;
      r_last     <= C_IDX_W'(C_CH - 1);
      r_tmo      <= '0;
      r_ack      <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_qq       <= '0;
      r_core_req <= 1'b0;
      r_core_dat <= '0;
    end else if (EN_CK_i) begin
      r_ack      <= '0;
      r_done     <= '0;
      r_err      <= '0;
      r_core_req <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_vld) begin
            r_core_dat <= w_dat;
            r_g        <= w_win;
            r_last     <= w_win;
            r_ack      <= w_win_mask;
            r_core_req <= 1'b1;
            r_state    <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          r_tmo   <= '0;
          r_state <= ST_WAIT;
        end
        ST_WAIT: begin
          r_tmo <= r_tmo + 1'b1;
          // done is checked first so a simultaneous done and timeout reports done
          if (bus.CORE_DONE_i) begin
            r_qq    <= bus.CORE_QQ_i;
            r_done  <= w_g_mask;
            r_state <= ST_IDLE;
          end else if (r_tmo == C_TMO_W'(C_TMO - 1)) begin
            r_err   <= w_g_mask;
            r_state <= ST_IDLE;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.ACK_o      = r_ack;
  assign bus.DONE_o     = r_done;
  assign bus.ERR_o      = r_err;
  assign bus.QQ_o       = r_qq;
  assign bus.CORE_REQ_o = r_core_req;
  assign bus.CORE_DAT_o = r_core_dat;
endmodule

// File: doc/bcd_conv_arbiter.md
# bcd_conv_arbiter

Round-robin scheduler that shares one shift-register binary-to-BCD converter core (27-bit binary in, 8-digit BCD out, REQ/DONE handshake) among `C_CH` requesters. It accepts a conversion request from one requester at a time and drives the core's request and data inputs. It waits for the core's done strobe, or aborts on a timeout. It then returns the BCD result with a per-channel done or error pulse. It sits between the display/telemetry producers and the single converter core instance.

## Interface
- `C_CH`, 4: number of requester channels (2..8)
- `C_TMO`, 63: max cycles in WAIT before abort; must exceed core latency (29)
- `CK_i`  in  1  clock
- `XARST_i`  in  1  reset, synchronous, active-low
- `EN_CK_i`  in  1  clock enable; low = all registers hold. The same signal also drives the core.
- `REQ_i`  in  C_CH  per-channel request level
- `DAT_i`  in  27*C_CH  per-channel binary operand; channel n at `[27n +: 27]`
- `ACK_o`  out  C_CH  one-cycle pulse: request of channel n accepted, DAT captured
- `DONE_o`  out  C_CH  one-cycle pulse: QQ_o valid for channel n
- `ERR_o`  out  C_CH  one-cycle pulse: channel n conversion timed out
- `QQ_o`  out  32  last BCD result, 8 digits, digit k at `[4k +: 4]`
- `CORE_REQ_o`  out  1  to core REQ_i
- `CORE_DAT_o`  out  27  to core DAT_i, registered
- `CORE_QQ_i`  in  32  from core QQ_o
- `CORE_DONE_i`  in  1  from core DONE_o

## Operation
- FSM states: IDLE, ISSUE, WAIT. All state changes occur only on CK_i edges where EN_CK_i=1.
- **IDLE**
  - If any REQ_i bit is high, pick a winner g with the round-robin rule: search starts at channel (last+1) mod C_CH.
  - At that edge: load CORE_DAT_o with DAT_i[g], store g, set last=g, go to ISSUE.
  - CORE_DONE_i is ignored in IDLE.
- **ISSUE** (exactly 1 cycle)
  - CORE_REQ_o=1 and ACK_o[g]=1.
  - Clear the timeout counter and go to WAIT.
  - A requester may drop REQ_i after the ACK edge. REQ_i still high after ACK counts as a new request.
- **WAIT**
  - Timeout counter increments each enabled cycle.
  - CORE_DONE_i=1: QQ_o<=CORE_QQ_i, DONE_o[g]=1 for the next cycle, go to IDLE.
  - Counter reaches C_TMO first: ERR_o[g]=1 for the next cycle, QQ_o unchanged, go to IDLE.
  - CORE_DONE_i and timeout in the same cycle: DONE wins.
- Operands above 99_999_999: QQ_o carries the low 8 decimal digits; no flag is raised.
- Channels with REQ_i low are never granted, and a granted channel is served once before the pointer advances. This guarantees starvation freedom: a held request waits at most C_CH-1 other conversions.
- DONE_o/ERR_o/ACK_o are registered, one-hot or zero, and never overlap.

## Timing
- Reset (XARST_i low at an edge) sets:
  - state=IDLE, last=C_CH-1 (so channel 0 has first priority)
  - ACK_o, DONE_o, ERR_o = 0; CORE_REQ_o=0; CORE_DAT_o=0; QQ_o=0; timeout counter=0
- Reset mid-WAIT aborts without any DONE_o/ERR_o pulse. The core must be reset by the same system reset.
- REQ_i sampled high at edge t (IDLE) gives ACK_o and CORE_REQ_o high in cycle t..t+1.
- CORE_DONE_i sampled at edge u gives DONE_o and QQ_o valid in cycle u..u+1.
- The earliest next grant is sampled at edge u+1. Turnaround overhead is 2 cycles plus core latency per conversion.
- EN_CK_i low: all outputs, including pulses, hold their value; the pulse ends on the next enabled edge.

## Structure
- Shared package `bin2bcd_pkg`:
  - `C_BIN_W`=27, `C_BCD_W`=32, `C_DIGITS`=8
  - state encoding constants (IDLE/ISSUE/WAIT)
- Sub-module `bcd_rr_pick`: combinational round-robin picker.
  - Inputs: REQ vector and last pointer.
  - Outputs: winner index and a valid flag.
- The timeout counter width is ceil(log2(C_TMO+1)).
- The core is not instantiated inside this block; the top level connects the CORE_* ports.

## Test plan
- **Single conversion:** ch0 REQ, DAT=27'd12345678, behavioral core → ACK_o=4'b0001 one cycle, DONE_o[0] after core latency, QQ_o=32'h12345678.
- **Round-robin order:** all four REQ held high with DAT=n*1000+7 → grants in order 0,1,2,3,0. Each QQ_o matches its channel's value (e.g. ch2 → 32'h00002007).
- **Truncation:** DAT=27'h7FFFFFF (134217727) → QQ_o=32'h34217727, DONE_o asserted, no ERR_o.
- **Timeout:** CORE_DONE_i tied 0 → ERR_o[g] exactly C_TMO+1 cycles after ISSUE, QQ_o unchanged. A subsequent request is granted normally.
- **Reset in WAIT:** XARST_i low for 1 cycle at WAIT cycle 10 → all outputs 0, no DONE_o/ERR_o. The next request goes to ch0 first.
- **Clock enable:** EN_CK_i low for 5 cycles during a DONE_o pulse → pulse stretches 5 cycles. State and QQ_o frozen, then resume.
